ascon_bdo_sink: RTL and testbench
=================================

// Module: ascon_bdo_sink
// PURPOSE
//  Receiving end of the Ascon core's bdo/auth output interface; sits between ascon_core and the host.
//  Buffers ciphertext/plaintext words in a FIFO with valid/ready towards the host.
//  Assembles the 128-bit tag and the 256-bit hash into registers, and latches the auth result.
//  Stalls the core via bdo_ready when it cannot accept a word.
// PARAMETERS
//  CCW        32  bdo/out data width in bits
//  FIFO_DEPTH 8   PTCT FIFO depth in words; must be a power of 2, >=2
//  TAG_WORDS  4   words per tag (TAG_WORDS*CCW = 128)
//  HASH_WORDS 8   words per hash (HASH_WORDS*CCW = 256)
// PORTS
//  clk        in  1          clock, all state on rising edge
//  rst_n      in  1          asynchronous active-low reset
//  clr        in  1          sync clear of FIFO, registers, FSM; wins over any same-cycle event
//  bdo        in  CCW        data word from core
//  bdo_valid  in  1          bdo word valid
//  bdo_ready  out 1          sink accepts bdo this cycle
//  bdo_type   in  4          D_PTCT / D_TAG / D_HASH, qualified by bdo_valid
//  bdo_eot    in  1          last word of current type
//  auth       in  1          tag verification result
//  auth_valid in  1          auth qualifier, single-cycle pulse
//  out_data   out CCW        FIFO head word
//  out_valid  out 1          FIFO non-empty
//  out_ready  in  1          host pops FIFO head
//  out_last   out 1          head word was received with bdo_eot
//  tag_q      out 128        assembled tag; word i at tag_q[CCW*i +: CCW]
//  tag_valid  out 1          tag complete, held until clr
//  hash_q     out 256        assembled hash; word i at hash_q[CCW*i +: CCW]
//  hash_valid out 1          hash complete, held until clr
//  auth_q     out 1          latched auth
//  auth_vld_q out 1          auth latched, held until clr
//  err        out 1          sticky protocol error, cleared only by clr or reset
// BEHAVIOUR
//  Reset (rst_n=0, async) and clr (sync):
//   - all outputs 0; FIFO empty; counters 0; FSM in S_IDLE.
//  Accept: a word is accepted on a cycle with bdo_valid && bdo_ready.
//  bdo_ready is combinational from state and FIFO count, never from bdo_valid:
//   - S_IDLE / S_PTCT: 1 if the FIFO is not full; 1 regardless of fill when bdo_type != D_PTCT.
//   - S_TAG / S_HASH: 1.
//   - S_DONE: 0 (core stalls until clr).
//  FSM:
//   - S_IDLE: accepted D_PTCT -> S_PTCT; D_TAG -> S_TAG; D_HASH -> S_HASH; word stored at index 0.
//   - S_PTCT: D_PTCT words push the FIFO; an accepted D_TAG starts the tag at index 0 -> S_TAG.
//   - S_TAG: word stored at index wcnt. S_TAG -> S_DONE with tag_valid=1 when wcnt == TAG_WORDS-1.
//   - S_HASH: same as S_TAG with HASH_WORDS; sets hash_valid=1 on the last word.
//   - S_DONE: hold.
//  tag_valid / hash_valid rise the cycle after the last word is accepted (1-cycle latency).
//  Wrong-type word in S_TAG/S_HASH: accepted, dropped, err=1, counters unchanged.
//  bdo_eot low on the final word, or high early: err=1; the count still governs completion.
//  FIFO:
//   - first-word-fall-through; out_data/out_last valid whenever out_valid.
//   - push and pop in the same cycle keep the count constant.
//   - no push when full (bdo_ready=0); pop when empty is ignored.
//   - pointers wrap mod FIFO_DEPTH; the count is $clog2(FIFO_DEPTH)+1 bits.
//  auth: on auth_valid, auth_q <= auth and auth_vld_q <= 1, in any state.
//   - A second auth_valid before clr overwrites auth_q and sets err.
//  rst_n asserted mid-tag: partial tag discarded, tag_valid stays 0.
// CONFIGURATION
//  ASCON_SINK_TAG_CMP_EN defined:
//   - adds input exp_tag[127:0] and outputs tag_match / tag_match_vld.
//   - tag_match_vld rises with tag_valid; tag_match = (tag_q == exp_tag), held until clr.
//  ASCON_SINK_TAG_CMP_EN undefined: these ports and the comparator are absent; all else identical.
// TESTING
//  1. rst_n=0 mid-run with FIFO holding 3 words -> all outputs 0 asynchronously; bdo_ready=1 after release.
//  2. 8 D_PTCT words 0x00..0x07 with out_ready=0 (FIFO_DEPTH=8) -> 9th word stalls with bdo_ready=0.
//     Then out_ready=1 pops 0x00..0x07 in order; out_last only on the word sent with bdo_eot.
//  3. 4 D_TAG words 0x11111111..0x44444444 -> tag_q=0x44444444_33333333_22222222_11111111.
//     tag_valid=1 one cycle after the 4th word; bdo_ready=0 afterwards until clr.
//  4. 8 D_HASH words k=0..7 -> hash_q word k matches; hash_valid=1; err=0.
//  5. D_PTCT word during S_TAG after 2 tag words -> err=1, tag completes after 2 more tag words.
//     Same-cycle clr with bdo_valid -> word dropped, all cleared.
//  6. auth_valid pulse with auth=1 -> auth_q=1, auth_vld_q=1.
//     With ASCON_SINK_TAG_CMP_EN and exp_tag equal to the test 3 tag -> tag_match=1; one bit flipped -> tag_match=0.

Source files
------------

// File: rtl/ascon_bdo_sink.sv
// Receiving end of the Ascon core bdo/auth interface: PTCT FIFO towards the host,
// tag/hash assembly registers and auth latch. Optional tag comparator: ASCON_SINK_TAG_CMP_EN.
module ascon_bdo_sink #(
  parameter int         CCW        = 32,
  parameter int         FIFO_DEPTH = 8,
  parameter int         TAG_WORDS  = 4,
  parameter int         HASH_WORDS = 8,
  parameter logic [3:0] D_PTCT     = 4'd1,
  parameter logic [3:0] D_TAG      = 4'd2,
  parameter logic [3:0] D_HASH     = 4'd3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [CCW-1:0]            bdo,
  input  logic                      bdo_valid,
  output logic                      bdo_ready,
  input  logic [3:0]                bdo_type,
  input  logic                      bdo_eot,
  input  logic                      auth,
  input  logic                      auth_valid,
  output logic [CCW-1:0]            out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic [TAG_WORDS*CCW-1:0]  tag_q,
  output logic                      tag_valid,
  output logic [HASH_WORDS*CCW-1:0] hash_q,
  output logic                      hash_valid,
  output logic                      auth_q,
  output logic                      auth_vld_q,
`ifdef ASCON_SINK_TAG_CMP_EN
  input  logic [TAG_WORDS*CCW-1:0]  exp_tag,
  output logic                      tag_match,
  output logic                      tag_match_vld,
`endif
  output logic                      err
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int MAXW = (HASH_WORDS > TAG_WORDS) ? HASH_WORDS : TAG_WORDS;
  localparam int WW   = $clog2(MAXW) + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0] TAG_LAST  = WW'(TAG_WORDS - 1);
  localparam logic [WW-1:0] HASH_LAST = WW'(HASH_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PTCT = 3'd1, S_TAG = 3'd2, S_HASH = 3'd3, S_DONE = 3'd4
  } state_t;

  state_t                    state, state_nxt;
  logic [CCW:0]              mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             count;
  logic [WW-1:0]             wcnt, idx;
  logic                      full, accept, pop, ready_st;
  logic                      push, tag_wr, hash_wr, fin_tag, fin_hash, type_err, eot_err;
  logic [TAG_WORDS*CCW-1:0]  tag_nxt;
  logic [HASH_WORDS*CCW-1:0] hash_nxt;

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != {CW{1'b0}});
  assign pop       = out_ready && out_valid;
  assign out_data  = out_valid ? mem[rd_ptr][CCW-1:0] : {CCW{1'b0}};
  assign out_last  = out_valid && mem[rd_ptr][CCW];
  // Ready never looks at bdo_valid; forced low while reset is asserted.
  assign bdo_ready = rst_n && ready_st;
  assign accept    = bdo_valid && bdo_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = push ? S_PTCT : (tag_wr ? S_TAG : (hash_wr ? S_HASH : S_IDLE));
      S_PTCT:  state_nxt = tag_wr ? S_TAG : S_PTCT;
      S_TAG:   state_nxt = fin_tag ? S_DONE : S_TAG;
      S_HASH:  state_nxt = fin_hash ? S_DONE : S_HASH;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Ready towards the core: only PTCT words can be blocked by a full FIFO
  always_comb begin
    ready_st = 1'b0;
    case (state)
      S_IDLE, S_PTCT: ready_st = (bdo_type != D_PTCT) || !full;
      S_TAG, S_HASH:  ready_st = 1'b1;
      default:        ready_st = 1'b0;
    endcase
  end

  // Output decode: routing of the accepted word and protocol error detection
  always_comb begin
    push = 1'b0; tag_wr = 1'b0; hash_wr = 1'b0; idx = wcnt;
    fin_tag = 1'b0; fin_hash = 1'b0; type_err = 1'b0; eot_err = 1'b0;
    case (state)
      S_IDLE, S_PTCT: begin
        if (!accept) begin
          push = 1'b0;
        end else if (bdo_type == D_PTCT) begin
          push = 1'b1;
        end else if (bdo_type == D_TAG) begin
          tag_wr = 1'b1; idx = {WW{1'b0}}; eot_err = bdo_eot;
        end else if ((bdo_type == D_HASH) && (state == S_IDLE)) begin
          hash_wr = 1'b1; idx = {WW{1'b0}}; eot_err = bdo_eot;
        end else begin
          type_err = 1'b1;
        end
      end
      S_TAG: begin
        if (!accept) begin
          tag_wr = 1'b0;
        end else if (bdo_type == D_TAG) begin
          tag_wr = 1'b1; fin_tag = (wcnt == TAG_LAST); eot_err = (bdo_eot != fin_tag);
        end else begin
          type_err = 1'b1;
        end
      end
      S_HASH: begin
        if (!accept) begin
          hash_wr = 1'b0;
        end else if (bdo_type == D_HASH) begin
          hash_wr = 1'b1; fin_hash = (wcnt == HASH_LAST); eot_err = (bdo_eot != fin_hash);
        end else begin
          type_err = 1'b1;
        end
      end
      default: type_err = 1'b0;
    endcase
  end

  // Merge the accepted word into the tag and hash images
  always_comb begin
    tag_nxt  = tag_q;
    hash_nxt = hash_q;
    for (int i = 0; i < TAG_WORDS; i++) begin
      if (tag_wr && (idx == WW'(i))) tag_nxt[CCW*i +: CCW] = bdo;
      else tag_nxt[CCW*i +: CCW] = tag_q[CCW*i +: CCW];
    end
    for (int i = 0; i < HASH_WORDS; i++) begin
      if (hash_wr && (idx == WW'(i))) hash_nxt[CCW*i +: CCW] = bdo;
      else hash_nxt[CCW*i +: CCW] = hash_q[CCW*i +: CCW];
    end
  end

  // FIFO storage; stale entries are never visible because out_* are gated by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bdo_eot, bdo};
  end

  // Pointers, counters, assembled results, auth latch and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= {AW{1'b0}}; rd_ptr <= {AW{1'b0}}; count <= {CW{1'b0}}; wcnt <= {WW{1'b0}};
      tag_q <= {(TAG_WORDS*CCW){1'b0}}; hash_q <= {(HASH_WORDS*CCW){1'b0}};
      tag_valid <= 1'b0; hash_valid <= 1'b0; auth_q <= 1'b0; auth_vld_q <= 1'b0; err <= 1'b0;
`ifdef ASCON_SINK_TAG_CMP_EN
      tag_match <= 1'b0; tag_match_vld <= 1'b0;
`endif
    end else if (clr) begin
      wr_ptr <= {AW{1'b0}}; rd_ptr <= {AW{1'b0}}; count <= {CW{1'b0}}; wcnt <= {WW{1'b0}};
      tag_q <= {(TAG_WORDS*CCW){1'b0}}; hash_q <= {(HASH_WORDS*CCW){1'b0}};
      tag_valid <= 1'b0; hash_valid <= 1'b0; auth_q <= 1'b0; auth_vld_q <= 1'b0; err <= 1'b0;
`ifdef ASCON_SINK_TAG_CMP_EN
      tag_match <= 1'b0; tag_match_vld <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (tag_wr || hash_wr) wcnt <= idx + WW'(1);
      tag_q  <= tag_nxt;
      hash_q <= hash_nxt;
      if (fin_tag)  tag_valid  <= 1'b1;
      if (fin_hash) hash_valid <= 1'b1;
      if (auth_valid) begin
        auth_q     <= auth;
        auth_vld_q <= 1'b1;
      end
      err <= err | type_err | eot_err | (auth_valid & auth_vld_q);
`ifdef ASCON_SINK_TAG_CMP_EN
      if (fin_tag) begin
        tag_match     <= (tag_nxt == exp_tag);
        tag_match_vld <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ascon_bdo_sink.sv
// Self-checking bench for ascon_bdo_sink: a queue/array model checked every cycle plus
// directed tests with literal expectations. Covers ASCON_SINK_TAG_CMP_EN when defined.
module tb_ascon_bdo_sink;
  localparam logic [3:0] D_PTCT = 4'd1;
  localparam logic [3:0] D_TAG  = 4'd2;
  localparam logic [3:0] D_HASH = 4'd3;

  logic clk, rst_n, clr, bdo_valid, bdo_ready, bdo_eot, auth, auth_valid;
  logic out_valid, out_ready, out_last, tag_valid, hash_valid, auth_q, auth_vld_q, err;
  logic [31:0]  bdo, out_data;
  logic [3:0]   bdo_type;
  logic [127:0] tag_q;
  logic [255:0] hash_q;
`ifdef ASCON_SINK_TAG_CMP_EN
  logic [127:0] exp_tag;
  logic         tag_match, tag_match_vld;
`endif

  ascon_bdo_sink dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bdo(bdo), .bdo_valid(bdo_valid),
    .bdo_ready(bdo_ready), .bdo_type(bdo_type), .bdo_eot(bdo_eot), .auth(auth),
    .auth_valid(auth_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .tag_q(tag_q), .tag_valid(tag_valid),
    .hash_q(hash_q), .hash_valid(hash_valid), .auth_q(auth_q), .auth_vld_q(auth_vld_q),
`ifdef ASCON_SINK_TAG_CMP_EN
    .exp_tag(exp_tag), .tag_match(tag_match), .tag_match_vld(tag_match_vld),
`endif
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [32:0]  mq[$];      // {last, data} words waiting for the host
  int           mode;       // 0 idle, 1 ptct, 2 tag, 3 hash, 4 done
  int           ntag, nhash;
  logic [127:0] m_tag;
  logic [255:0] m_hash;
  bit           m_tv, m_hv, m_err, m_auth, m_av;

  function automatic void m_clear();
    mq.delete(); mode = 0; ntag = 0; nhash = 0; m_tag = '0; m_hash = '0;
    m_tv = 0; m_hv = 0; m_err = 0; m_auth = 0; m_av = 0;
  endfunction

  function automatic bit m_ready();
    if (!rst_n) return 1'b0;
    if (mode == 4) return 1'b0;
    if (mode == 2 || mode == 3) return 1'b1;
    return (bdo_type != D_PTCT) || (mq.size() < 8);
  endfunction

  function automatic void m_word();
    if (mode == 0 || mode == 1) begin
      if (bdo_type == D_PTCT) begin
        mq.push_back({bdo_eot, bdo}); mode = 1;
      end else if (bdo_type == D_TAG) begin
        m_tag[31:0] = bdo; ntag = 1; mode = 2; if (bdo_eot) m_err = 1;
      end else if (bdo_type == D_HASH && mode == 0) begin
        m_hash[31:0] = bdo; nhash = 1; mode = 3; if (bdo_eot) m_err = 1;
      end else m_err = 1;
    end else if (mode == 2) begin
      if (bdo_type == D_TAG) begin
        m_tag[32*ntag +: 32] = bdo; ntag++;
        if (bdo_eot != (ntag == 4)) m_err = 1;
        if (ntag == 4) begin mode = 4; m_tv = 1; end
      end else m_err = 1;
    end else if (mode == 3) begin
      if (bdo_type == D_HASH) begin
        m_hash[32*nhash +: 32] = bdo; nhash++;
        if (bdo_eot != (nhash == 8)) m_err = 1;
        if (nhash == 8) begin mode = 4; m_hv = 1; end
      end else m_err = 1;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_step
    bit acc;
    if (!rst_n) m_clear();
    else begin
      acc = bdo_valid && m_ready();
      if (clr) m_clear();
      else begin
        if (out_ready && mq.size() > 0) void'(mq.pop_front());
        if (acc) m_word();
        if (auth_valid) begin
          if (m_av) m_err = 1;
          m_auth = auth; m_av = 1;
        end
      end
    end
  end

  // Per-cycle compare against the model, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("bdo_ready", bdo_ready, m_ready());
      check("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("out_data", out_data, mq[0][31:0]);
        check("out_last", out_last, mq[0][32]);
      end
      check("tag_valid", tag_valid, m_tv);
      check("tag_q", tag_q, m_tag);
      check("hash_valid", hash_valid, m_hv);
      check("hash_q", hash_q, m_hash);
      check("auth_q", auth_q, m_auth);
      check("auth_vld_q", auth_vld_q, m_av);
      check("err", err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic send(input logic [3:0] t, input logic [31:0] d, input logic e);
    int n;
    bdo_type = t; bdo = d; bdo_eot = e; bdo_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!bdo_ready && n < 20) begin n++; @(negedge clk); end
    check("send_ready", bdo_ready, 1'b1);
    @(posedge clk); #1;
    bdo_valid = 1'b0; bdo_eot = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    m_clear();
    rst_n = 0; clr = 0; bdo = '0; bdo_valid = 0; bdo_type = '0; bdo_eot = 0;
    auth = 0; auth_valid = 0; out_ready = 0;
`ifdef ASCON_SINK_TAG_CMP_EN
    exp_tag = 128'h44444444_33333333_22222222_11111111;
`endif
    repeat (2) tick();
    rst_n = 1; chk_en = 1;
    tick();

    // 1: async reset with three words buffered
    for (int i = 1; i <= 3; i++) send(D_PTCT, 32'(i), 1'b0);
    check("pre_rst_valid", out_valid, 1'b1);
    #1 rst_n = 0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_bdo_ready", bdo_ready, 1'b0);
    tick(); rst_n = 1; #1;
    check("ready_after_rst", bdo_ready, 1'b1);

    // 2: fill FIFO, 9th stalls, then drain in order
    for (int i = 0; i < 8; i++) send(D_PTCT, 32'(i), i == 7);
    bdo_valid = 1; bdo = 32'h8; bdo_eot = 0;
    @(negedge clk);
    check("stall_ready", bdo_ready, 1'b0);
    tick(); bdo_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("pop_valid", out_valid, 1'b1);
      check("pop_data", out_data, 32'(i));
      check("pop_last", out_last, i == 7);
      @(posedge clk); #1;
    end
    check("drained", out_valid, 1'b0);
    out_ready = 0;
    do_clr();

    // 3: tag assembly and stall in done
    for (int i = 0; i < 4; i++) begin
      w = 32'h11111111 * (i + 1);
      if (i == 3) check("tag_valid_early", tag_valid, 1'b0);
      send(D_TAG, w, i == 3);
    end
    check("tag_valid_lat", tag_valid, 1'b1);
    check("tag_q_lit", tag_q, 128'h44444444_33333333_22222222_11111111);
    bdo_valid = 1; bdo_type = D_TAG;
    @(negedge clk);
    check("done_ready", bdo_ready, 1'b0);
    tick(); bdo_valid = 0;

    // 6a: auth latch
    auth = 1; auth_valid = 1; tick(); auth_valid = 0; auth = 0;
    check("auth_q_lit", auth_q, 1'b1);
    check("auth_vld_lit", auth_vld_q, 1'b1);
    check("err_auth_once", err, 1'b0);
`ifdef ASCON_SINK_TAG_CMP_EN
    check("tag_match_eq", tag_match, 1'b1);
    check("tag_match_vld", tag_match_vld, 1'b1);
`endif
    do_clr();
    check("clr_tag_valid", tag_valid, 1'b0);

    // 4: hash assembly
    for (int k = 0; k < 8; k++) send(D_HASH, 32'hC0DE0000 + 32'(k), k == 7);
    for (int k = 0; k < 8; k++) check("hash_word", hash_q[32*k +: 32], 32'hC0DE0000 + 32'(k));
    check("hash_valid_lit", hash_valid, 1'b1);
    check("hash_err", err, 1'b0);
    do_clr();

    // concurrent push and pop
    out_ready = 1;
    for (int i = 0; i < 6; i++) send(D_PTCT, 32'hA5A50000 + 32'(i), i == 5);
    repeat (3) tick();
    check("flow_drained", out_valid, 1'b0);
    out_ready = 0;
    do_clr();

    // 5: wrong-type word inside a tag
    for (int i = 0; i < 2; i++) send(D_TAG, 32'hAAAA0000 + 32'(i), 1'b0);
    send(D_PTCT, 32'hDEADBEEF, 1'b0);
    check("wrong_type_err", err, 1'b1);
    for (int i = 2; i < 4; i++) send(D_TAG, 32'hAAAA0000 + 32'(i), i == 3);
    check("wt_tag_valid", tag_valid, 1'b1);
    check("wt_tag_q", tag_q, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000);
    check("wt_no_push", out_valid, 1'b0);
    do_clr();
    bdo_type = D_PTCT; bdo = 32'h12345678; bdo_valid = 1; clr = 1;
    tick();
    clr = 0; bdo_valid = 0;
    check("clr_drop_valid", out_valid, 1'b0);
    check("clr_err", err, 1'b0);

`ifdef ASCON_SINK_TAG_CMP_EN
    exp_tag = 128'h44444444_33333333_22222222_11111110;
    for (int i = 0; i < 4; i++) send(D_TAG, 32'h11111111 * 32'(i + 1), i == 3);
    check("tag_match_ne", tag_match, 1'b0);
    check("tag_match_vld2", tag_match_vld, 1'b1);
    do_clr();
`endif

    // 6b: second auth overwrites and flags an error
    auth = 1; auth_valid = 1; tick();
    auth = 0; tick(); auth_valid = 0;
    check("auth_overwrite", auth_q, 1'b0);
    check("auth_twice_err", err, 1'b1);
    do_clr();
    tick();

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
